// File: rtl/gesture_filter_if.sv
// Signal bundle between the PAJ7620 gesture reader and the gesture filter.
interface gesture_filter_if;
  logic [7:0] data;
  logic [3:0] flag;
  logic       gest_vld;
  logic       busy;

  modport master (
    output data,
    input  flag,
    input  gest_vld,
    input  busy
  );

  modport slave (
    input  data,
    output flag,
    output gest_vld,
    output busy
  );
endinterface

// File: rtl/gesture_filter.sv
// Debounces one-hot gesture codes and latches each accepted gesture into flag.
// The flag auto-clears a programmable number of clocks after acceptance.
module gesture_filter #(
  parameter int unsigned STABLE_CNT = 50_000,
  parameter int unsigned TIMEOUT    = 150_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  gesture_filter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CONFIRM  = 2'b01,
    COMMIT   = 2'b10,
    WAIT_REL = 2'b11
  } state_t;

  localparam logic [19:0] STAB_LAST = 20'(STABLE_CNT - 1);
  localparam logic [27:0] TO_LAST   = 28'(TIMEOUT - 1);
  localparam bit          TO_EN     = (TIMEOUT != 0);

  state_t      state;
  state_t      state_next;
  logic [3:0]  code;
  logic [3:0]  code_r;
  logic [3:0]  code_next;
  logic [19:0] stab_cnt;
  logic [19:0] stab_next;
  logic [27:0] to_cnt;
  logic [3:0]  flag_r;
  logic        gest_vld_r;
  logic        code_valid;
  logic        code_match;

  assign code       = bus.data[3:0];
  assign code_valid = (code == 4'b0001) || (code == 4'b0010) ||
                      (code == 4'b0100) || (code == 4'b1000);
  assign code_match = (code == code_r);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      code_r   <= '0;
      stab_cnt <= '0;
    end else begin
      state    <= state_next;
      code_r   <= code_next;
      stab_cnt <= stab_next;
    end
  end

  always_comb begin
    state_next = state;
    code_next  = code_r;
    stab_next  = stab_cnt;
    unique case (state)
      IDLE: begin
        if (code_valid) begin
          code_next  = code;
          stab_next  = '0;
          state_next = CONFIRM;
        end
      end
      CONFIRM: begin
        if (code_match) begin
          stab_next = stab_cnt + 20'd1;
          if (stab_cnt == STAB_LAST) begin
            state_next = COMMIT;
          end
        end else if (code_valid) begin
          code_next = code;
          stab_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      COMMIT: begin
        state_next = WAIT_REL;
      end
      WAIT_REL: begin
        if (!code_match) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // COMMIT takes priority over a coinciding timeout expiry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flag_r     <= '0;
      gest_vld_r <= 1'b0;
      to_cnt     <= '0;
    end else begin
      gest_vld_r <= (state == COMMIT);
      if (state == COMMIT) begin
        flag_r <= code_r;
        to_cnt <= '0;
      end else if (TO_EN && (flag_r != '0)) begin
        if (to_cnt == TO_LAST) begin
          flag_r <= '0;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 28'd1;
        end
      end
    end
  end

  assign bus.flag     = flag_r;
  assign bus.gest_vld = gest_vld_r;
  assign bus.busy     = (state == CONFIRM) || (state == WAIT_REL);

endmodule

// File: tb/tb_gesture_filter.sv
// Bench for gesture_filter: directed scenarios plus randomized hold patterns,
// compared every cycle against a run-length model of the acceptance rules.
module tb_gesture_filter;

  localparam int STABLE = 4;
  localparam int TOUT   = 20;

  logic clk;
  logic rst_n;

  gesture_filter_if bus ();

  gesture_filter #(
    .STABLE_CNT (STABLE),
    .TIMEOUT    (TOUT)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: count consecutive identical one-hot samples; a run of STABLE+1
  // samples schedules a commit on the next edge, after which the code must be
  // released (one consumed sample) before a new run may start.
  int         m_run;
  logic [3:0] m_code;
  bit         m_pend;
  bit         m_holding;
  logic [3:0] m_flag;
  bit         m_vld;
  int         m_age;

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] d;
    bit committed;
    if (!rst_n) begin
      m_run = 0; m_code = '0; m_pend = 0; m_holding = 0;
      m_flag = '0; m_vld = 0; m_age = 0;
    end else begin
      d = bus.data[3:0];
      committed = m_pend;
      m_vld = 0;
      if (!committed && m_flag != 0) begin
        m_age++;
        if (m_age == TOUT) begin
          m_flag = '0;
          m_age = 0;
        end
      end
      if (committed) begin
        m_pend = 0;
        m_flag = m_code;
        m_vld = 1;
        m_age = 0;
        m_holding = 1;
        m_run = 0;
      end else if (m_holding) begin
        if (d != m_code) m_holding = 0;
      end else if ($countones(d) == 1) begin
        if (m_run > 0 && d == m_code) m_run++;
        else begin
          m_code = d;
          m_run = 1;
        end
        if (m_run == STABLE + 1) m_pend = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
    chk("flag", int'(bus.flag), int'(m_flag));
    chk("gest_vld", int'(bus.gest_vld), int'(m_vld));
    chk("busy", int'(bus.busy), int'((m_run > 0 && !m_pend) || m_holding));
  end

  task automatic drive(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus.data = d;
      @(negedge clk);
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flag", int'(bus.flag), 0);
    chk("rst_vld", int'(bus.gest_vld), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] bad [3];
    logic [7:0] pick;
    int n;
    bad[0] = 8'h03; bad[1] = 8'h06; bad[2] = 8'hF0;

    rst_n = 1'b0;
    bus.data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_flag", int'(bus.flag), 0);
    chk("reset_vld", int'(bus.gest_vld), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hold 02: pulse on the sixth edge carrying it, exactly once.
    drive(8'h02, 5);
    chk("g02_early", int'(bus.gest_vld), 0);
    drive(8'h02, 1);
    chk("g02_vld", int'(bus.gest_vld), 1);
    chk("g02_flag", int'(bus.flag), 2);
    drive(8'h02, 4);
    chk("g02_once", int'(bus.gest_vld), 0);
    chk("g02_wait", int'(bus.busy), 1);
    drive(8'h00, 2);

    // Short 01 then invalid: no acceptance, flag keeps 0010.
    drive(8'h01, 3);
    drive(8'h00, 1);
    chk("short_vld", int'(bus.gest_vld), 0);
    chk("short_flag", int'(bus.flag), 2);

    // 01 interrupted by 04: restart timed from the first 04.
    drive(8'h01, 2);
    drive(8'h04, 5);
    chk("g04_early", int'(bus.gest_vld), 0);
    drive(8'h04, 1);
    chk("g04_vld", int'(bus.gest_vld), 1);
    chk("g04_flag", int'(bus.flag), 4);
    drive(8'h00, 2);

    for (int i = 0; i < 3; i++) begin
      drive(bad[i], 10);
      chk("bad_busy", int'(bus.busy), 0);
    end

    // Accept 08 then release: flag holds 20 clocks after the commit edge.
    drive(8'h08, 6);
    chk("g08_vld", int'(bus.gest_vld), 1);
    drive(8'h00, 19);
    chk("to_hold", int'(bus.flag), 8);
    drive(8'h00, 1);
    chk("to_clear", int'(bus.flag), 0);
    chk("to_novld", int'(bus.gest_vld), 0);

    drive(8'h01, 6);
    chk("g01_flag", int'(bus.flag), 1);
    drive(8'h00, 19);
    drive(8'h02, 6);
    chk("g02b_flag", int'(bus.flag), 2);
    drive(8'h02, 2);
    drive(8'h00, 1);
    drive(8'hA2, 6);
    chk("reacc_vld", int'(bus.gest_vld), 1);
    chk("reacc_flag", int'(bus.flag), 2);
    drive(8'h00, 1);
    drive(8'h04, 3);
    chk("confirm_busy", int'(bus.busy), 1);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: pick = {4'($urandom_range(0, 15)), 4'(1 << $urandom_range(0, 3))};
        3:       pick = 8'h00;
        4:       pick = 8'(32'h0000_0003 << $urandom_range(0, 2));
        default: pick = 8'($urandom);
      endcase
      n = int'($urandom_range(1, 9));
      drive(pick, n);
      if ($urandom_range(0, 49) == 0) async_reset();
    end

    drive(8'h00, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gesture_filter.md
GESTURE_FILTER -- requirements
Module: gesture_filter

Interface
REQ-001 Parameter STABLE_CNT, default 50_000, is the number of consecutive clocks a gesture code must hold before it is accepted (1 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter TIMEOUT, default 150_000_000, is the number of clocks after acceptance before flag auto-clears (3 s); 0 disables auto-clear; legal range 0..2^28-1.
REQ-003 sys_clk  in  1  system clock, 50 MHz.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 data  in  8  raw gesture byte from the PAJ7620 reader; bits[3:0] carry up/down/left/right, bits[7:4] are ignored.
REQ-006 flag  out  4  latched one-hot accepted gesture; 4'b0000 means none.
REQ-007 gest_vld  out  1  single-cycle pulse on each accepted gesture.
REQ-008 busy  out  1  high while in CONFIRM or WAIT_REL.

Function
REQ-009 A code is valid only when data[3:0] is exactly one-hot (0001, 0010, 0100 or 1000); 0000 and multi-bit values are invalid.
REQ-010 The FSM shall have states IDLE, CONFIRM, COMMIT and WAIT_REL, with a binary encoding and IDLE as the reset state.
REQ-011 IDLE: on a valid data[3:0], capture it into code_r, clear stab_cnt to 0, and go to CONFIRM; otherwise stay in IDLE.
REQ-012 CONFIRM, data[3:0] == code_r: increment stab_cnt; at stab_cnt == STABLE_CNT-1, go to COMMIT.
REQ-013 CONFIRM, data[3:0] != code_r and valid: recapture code_r, clear stab_cnt, and stay in CONFIRM (restart).
REQ-014 CONFIRM, data[3:0] invalid: go to IDLE; flag is unchanged.
REQ-015 COMMIT lasts exactly one cycle: flag <= code_r, gest_vld = 1, timeout counter cleared, then go to WAIT_REL.
REQ-016 WAIT_REL: stay while data[3:0] == code_r, so a held gesture produces exactly one gest_vld.
REQ-017 WAIT_REL: when data[3:0] differs from code_r, go to IDLE; a new valid code is then evaluated from IDLE on the following cycle.
REQ-018 Latency: with a valid code first present at edge N and held constant, gest_vld is high during the cycle after edge N+STABLE_CNT+1, and flag updates on that same edge.
REQ-019 The same code re-accepted after a release shall pulse gest_vld again and rewrite flag with the same value.
REQ-020 Auto-clear applies only when TIMEOUT != 0 and flag != 0: to_cnt increments every cycle in any state except COMMIT.
REQ-021 When to_cnt == TIMEOUT-1, flag <= 0 and to_cnt holds at 0 until the next COMMIT; gest_vld is not asserted on clear.
REQ-022 If COMMIT and timeout expiry coincide, COMMIT wins: flag = new code and to_cnt = 0.
REQ-023 stab_cnt is 20 bits and to_cnt is 28 bits; neither counter wraps, since both are compared for equality and cleared or held.
REQ-024 gest_vld and flag shall be registered outputs with no combinational path from data.
REQ-025 busy = (state == CONFIRM) || (state == WAIT_REL), registered or decoded from the state register.

Reset
REQ-026 While sys_rst_n = 0: state = IDLE, code_r = 0, stab_cnt = 0, to_cnt = 0, flag = 4'b0000, gest_vld = 0, busy = 0.
REQ-027 Reset asserted mid-CONFIRM or mid-WAIT_REL shall abort immediately, with no gest_vld pulse and flag cleared.
REQ-028 After reset release, the first evaluation of data is at the first rising edge following release.

Verification (STABLE_CNT=4, TIMEOUT=20)
REQ-029 Hold data=8'h02 for 10 clocks -> exactly one gest_vld, 6 clocks after the first edge with 02; flag=0010.
REQ-030 Apply 01 for 3 clocks, then 00 -> no gest_vld; flag keeps its prior value.
REQ-031 Apply 01 for 2 clocks, then 04 held -> CONFIRM restarts; gest_vld 6 clocks after 04 first appears; flag=0100.
REQ-032 Apply 03, 06 or F0 held 10 clocks -> no acceptance; state stays IDLE.
REQ-033 Accept 08, then release to 00 -> flag=1000 for exactly 20 clocks after the COMMIT cycle, then 0000 with no pulse.
REQ-034 Accept 01, wait 19 clocks, accept 02 -> flag=0010 and the timeout restarts; assert sys_rst_n=0 during CONFIRM -> all outputs 0 at once.
